// File: rtl/merge_pipe_if.sv
// merge_pipe_if: handshake bundle for merge_pipe.
//
// Ports (as interface signals):
//   in_valid / in_ready   input-side valid/ready pair
//   op [N*W]              operands, channel c at bits [c*W +: W]
//   sel [SELW]            channel select, SELW = $clog2(N)
//   mode [2]              merge function
//   out_valid / out_ready output-side valid/ready pair
//   out [W], out_killed   result and its kill flag
//   kill_cnt [16]         saturating count of killed transactions accepted
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds valid and its payload steady until that
// edge; ready may depend combinationally on the consumer's ready.
//
// Modports: master drives the transaction and the output-side ready;
// slave is the merge_pipe side.
interface merge_pipe_if #(
    parameter int W = 32,
    parameter int N = 2
);
    localparam int SELW = $clog2(N);

    logic            in_valid;
    logic            in_ready;
    logic [N*W-1:0]  op;
    logic [SELW-1:0] sel;
    logic [1:0]      mode;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out;
    logic            out_killed;
    logic [15:0]     kill_cnt;

    modport master (
        output in_valid, op, sel, mode, out_ready,
        input  in_ready, out_valid, out, out_killed, kill_cnt
    );

    modport slave (
        input  in_valid, op, sel, mode, out_ready,
        output in_ready, out_valid, out, out_killed, kill_cnt
    );
endinterface

// File: rtl/merge_pipe.sv
// merge_pipe: N-channel operand merge followed by a DEPTH-stage elastic
// register pipeline.
//
// Each accepted transaction reduces N W-bit operands to one W-bit value:
//   mode 0: operand of the selected channel
//   mode 1: sign bit (MSB) of the selected channel, zero-extended
//   mode 2: OR of all channels
//   mode 3: XOR of all channels
// A select value >= N picks channel 0. If any channel has bit KBIT set the
// transaction is killed: it carries data 0 and killed = 1.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    merge_pipe_if slave modport (see interface for signal list)
module merge_pipe #(
    parameter int W     = 32,
    parameter int N     = 2,
    parameter int DEPTH = 2,
    parameter int KBIT  = W - 2
) (
    input logic         clk,
    input logic         rst_n,
    merge_pipe_if.slave bus
);
    localparam int SELW = $clog2(N);

    // ------------------------------------------------------------------
    // Merge function
    // ------------------------------------------------------------------
    logic [W-1:0] picked;
    logic [W-1:0] or_all;
    logic [W-1:0] xor_all;
    logic [W-1:0] merge_x;
    logic         kill;

    always_comb begin
        // Channel 0 is the fallback: an out-of-range select matches no c.
        picked  = bus.op[W-1:0];
        or_all  = '0;
        xor_all = '0;
        kill    = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (SELW'(c) == bus.sel) begin
                picked = bus.op[c*W +: W];
            end
            or_all  = or_all | bus.op[c*W +: W];
            xor_all = xor_all ^ bus.op[c*W +: W];
            kill    = kill | bus.op[c*W + KBIT];
        end

        merge_x = picked;
        case (bus.mode)
            2'd0:    merge_x = picked;
            2'd1:    merge_x = {{(W-1){1'b0}}, picked[W-1]};
            2'd2:    merge_x = or_all;
            default: merge_x = xor_all;
        endcase
    end

    // ------------------------------------------------------------------
    // Elastic pipeline
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH-1:0]        killed_q, killed_d;
    logic [DEPTH-1:0][W-1:0] data_q, data_d;
    logic [15:0]             kill_cnt_q, kill_cnt_d;

    // rdy[i] is the ready of stage i (0-based); rdy[DEPTH] is the consumer.
    // An empty stage is always ready, so bubbles collapse under back-pressure.
    logic [DEPTH:0] rdy;
    logic           accept;

    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !valid_q[i] || rdy[i+1];
        end
    end

    assign accept = bus.in_valid && rdy[0];

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        killed_d   = killed_q;
        kill_cnt_d = kill_cnt_q;

        // Payload registers load only behind a valid upstream entry, so a
        // bubble moving through leaves the old data in place.
        if (rdy[0]) begin
            valid_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                data_d[0]   = kill ? '0 : merge_x;
                killed_d[0] = kill;
            end
        end

        for (int i = 1; i < DEPTH; i++) begin
            if (rdy[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_d[i]   = data_q[i-1];
                    killed_d[i] = killed_q[i-1];
                end
            end
        end

        // Counted at acceptance, not at exit; sticks at all-ones.
        if (accept && kill && (kill_cnt_q != 16'hFFFF)) begin
            kill_cnt_d = kill_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            data_q     <= '0;
            killed_q   <= '0;
            kill_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            killed_q   <= killed_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end

    assign bus.in_ready   = rdy[0];
    assign bus.out_valid  = valid_q[DEPTH-1];
    assign bus.out        = data_q[DEPTH-1];
    assign bus.out_killed = killed_q[DEPTH-1];
    assign bus.kill_cnt   = kill_cnt_q;
endmodule

// File: doc/merge_pipe.md
# merge_pipe

Parametrised N-channel operand merge pipeline with a valid/ready handshake. Each accepted transaction reduces N W-bit operands to one W-bit result under a per-transaction mode and channel select. A kill condition forces the result to zero. The result then travels through a DEPTH-stage elastic register pipeline. The block generalises the two-operand select/clear/register pattern used in the information-flow test designs, and is the standard fixture for multi-channel taint-propagation checks through stallable pipelines.

## Interface
- W, 32, operand and result width (≥2)
- N, 2, number of operand channels (≥2)
- DEPTH, 2, register stages from input to `out` (≥1)
- KBIT, W-2, kill-bit index inside each operand
- SELW, $clog2(N), select width (derived, not overridden)

- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  transaction present on op/sel/mode
- in_ready  output  1  block accepts this cycle
- op  input  N*W  channel c occupies bits [c*W +: W]
- sel  input  SELW  channel select
- mode  input  2  merge function
- out_valid  output  1  `out` holds a result
- out_ready  input  1  consumer accepts `out`
- out  output  W  result
- out_killed  output  1  result at `out` was killed
- kill_cnt  output  16  killed transactions accepted, saturating

## Operation
- Channel select: `sel` ≥ N selects channel 0.
- Merge value x, computed combinationally from the inputs:
  - mode 0: x = op[sel] (pass-through).
  - mode 1: x = zero-extended op[sel][W-1] (sign bit, LSB only).
  - mode 2: x = bitwise OR of all N channels.
  - mode 3: x = bitwise XOR of all N channels.
- Kill: kill = OR over all channels of op[c][KBIT], independent of mode and sel. Stage 1 captures data 0 and killed = 1 when kill = 1; otherwise it captures data x and killed = 0.
- Pipeline: stages S1..S_DEPTH, each holding {valid, data, killed}. `out`/`out_killed`/`out_valid` are S_DEPTH.
- Ready chain:
  - ready_i = !valid_i | ready_(i+1)
  - ready_(DEPTH+1) = out_ready
  - in_ready = ready_1, which is combinational and depends on out_ready.
- Stage i loads from stage i-1 (stage 1 loads from the input) when ready_i.
  - valid_i takes the upstream valid, with valid_0 = in_valid.
  - data and killed load only when the upstream valid is 1; otherwise they hold. Bubbles therefore do not clobber data.
- Bubbles collapse: an empty stage always accepts, even while out_ready = 0.
- Transfers:
  - Accept: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- kill_cnt increments on each accepted transaction with kill = 1. It stops at 16'hFFFF.
- Reset (asynchronous assert, release synchronous to clk, handled by the integrator):
  - All valid = 0, data = 0, killed = 0, kill_cnt = 0.
  - Outputs during and after reset: out = 0, out_valid = 0, out_killed = 0, in_ready = 1.
- Reset mid-operation discards all in-flight transactions. Nothing is replayed.

## Timing
- Latency: a transaction accepted at edge t is presented on `out` with out_valid = 1 from edge t+DEPTH-1, given no back-pressure.
  - DEPTH = 1: visible the cycle after acceptance.
  - DEPTH = 2: two-register behaviour, matching the y/out pattern.
- Throughput: one transaction per cycle while out_ready = 1.
- Hold: while out_valid & !out_ready, out and out_killed are stable and the transaction is not lost.
- Full pipeline with out_ready = 0: in_ready = 0 in the same cycle.
- Simultaneous output transfer and input accept on a full pipeline: both occur on the same edge, with no bubble inserted.
- Order is strictly preserved. There is no reordering and no duplication.
- kill_cnt updates on the accepting edge, not when the result exits.

## Test plan
- Reset and mode 0 stream, DEPTH=2, N=2:
  - Stimulus: assert rst_n = 0 mid-stream, release, then send 3 transactions back-to-back with mode 0. Transactions: sel=1 with op1=32'h0000_1234 (bit 30 clear in all channels); then sel=0 and sel=1 variants.
  - Required: out = 0 and out_valid = 0 during reset. After release, out = 32'h0000_1234 at edge t+1. Subsequent results follow one per cycle.
- Modes 1/2/3, N=4:
  - Stimulus: op = {32'h8000_0001, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_F000} (channel 3 first), sel=3.
  - Required: mode 1 → out = 1. Mode 2 → out = 32'h8000_FFF1. Mode 3 → out = 32'h8000_FFF1.
- Kill:
  - Stimulus: channel 2 carries 32'h4000_0000 (KBIT = 30) in a mode 2 transaction.
  - Required: out = 0, out_killed = 1, kill_cnt increments by exactly 1 at the accepting edge.
  - Saturation: with kill_cnt preloaded to 16'hFFFF by forcing, a further kill leaves it at 16'hFFFF.
- Back-pressure, DEPTH=3:
  - Stimulus: hold out_ready = 0 while feeding 5 transactions with values 1–5.
  - Required: exactly 3 accepted, in_ready = 0 afterwards, out holds 1 stable. Release out_ready for 5 cycles: out sequence is 1, 2, 3, 4, 5 with no gaps or duplicates.
- Bubble collapse and out-of-range select:
  - Stimulus: with out_ready = 0, send one transaction, idle 2 cycles, send a second. Separately, send sel = 3 with N = 3.
  - Required: both transactions are accepted, and the second sits directly behind the first. The sel = 3 transaction returns channel 0.
